// File: rtl/sequenciador_carga.sv
// Operand loader: fills up to six 16-bit destinations one word per valid/ready transfer.
// Optional running checksum on soma is enabled by defining SEQUENCIADOR_CARGA_SOMA_EN.
module sequenciador_carga #(
  parameter int unsigned N_DESTINOS = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iniciar,
  input  logic        entrada_valida,
  input  logic [15:0] entrada,
  output logic        entrada_pronta,
  output logic [2:0]  op,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [15:0] c,
  output logic [15:0] d,
  output logic [15:0] e,
  output logic [15:0] f,
  output logic        ocupado,
  output logic        pronto,
  output logic [15:0] soma
);

  localparam int unsigned W      = 16;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned N_MAX  = 6;
  localparam logic [OP_W-1:0] OP_OCIOSO = 3'b111;
  localparam logic [OP_W-1:0] OP_ULTIMO = OP_W'(N_DESTINOS - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            pronta_q, pronta_d;
  logic            ocupado_q, ocupado_d;
  logic            pronto_q, pronto_d;
  logic            transfer_c;

  // Ready is a flop that is high exactly while loading, so it qualifies the handshake.
  assign transfer_c = pronta_q && entrada_valida;

  // State and registered control outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= OCIOSO;
      op_q      <= OP_OCIOSO;
      pronta_q  <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      op_q      <= op_d;
      pronta_q  <= pronta_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  // Next state plus the values the control outputs take after this edge.
  always_comb begin
    estado_d  = estado_q;
    op_d      = op_q;
    pronta_d  = 1'b0;
    ocupado_d = 1'b0;
    pronto_d  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        op_d = OP_OCIOSO;
        if (iniciar) begin
          estado_d  = CARREGA;
          op_d      = '0;
          pronta_d  = 1'b1;
          ocupado_d = 1'b1;
        end
      end
      CARREGA: begin
        pronta_d  = 1'b1;
        ocupado_d = 1'b1;
        if (transfer_c) begin
          if (op_q == OP_ULTIMO) begin
            estado_d = FIM;
            op_d     = OP_OCIOSO;
            pronta_d = 1'b0;
            pronto_d = 1'b1;
          end else begin
            op_d = OP_W'(op_q + 3'd1);
          end
        end
      end
      FIM: begin
        estado_d = OCIOSO;
        op_d     = OP_OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
        op_d     = OP_OCIOSO;
      end
    endcase
  end

  logic [N_MAX-1:0][W-1:0] destino_c;

  // Only destinations inside the configured run length get storage.
  for (genvar i = 0; i < N_MAX; i++) begin : g_destino
    if (i < N_DESTINOS) begin : g_ativo
      logic [W-1:0] valor_q;
      logic         escreve_c;

      assign escreve_c = transfer_c && (op_q == OP_W'(i));

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          valor_q <= '0;
        end else if (escreve_c) begin
          valor_q <= entrada;
        end
      end

      assign destino_c[i] = valor_q;
    end else begin : g_inativo
      assign destino_c[i] = '0;
    end
  end

`ifdef SEQUENCIADOR_CARGA_SOMA_EN
  logic [W-1:0] soma_q;
  logic         inicio_c;

  assign inicio_c = (estado_q == OCIOSO) && iniciar;

  // Modulo-2^16 accumulation of every accepted word in the current run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      soma_q <= '0;
    end else if (inicio_c) begin
      soma_q <= '0;
    end else if (transfer_c) begin
      soma_q <= W'(soma_q + entrada);
    end
  end

  assign soma = soma_q;
`else
  assign soma = '0;
`endif

  assign entrada_pronta = pronta_q;
  assign op             = op_q;
  assign ocupado        = ocupado_q;
  assign pronto         = pronto_q;
  assign a              = destino_c[0];
  assign b              = destino_c[1];
  assign c              = destino_c[2];
  assign d              = destino_c[3];
  assign e              = destino_c[4];
  assign f              = destino_c[5];

endmodule

// File: tb/tb_sequenciador_carga.sv
// Bench for sequenciador_carga: a 6-destination and a 3-destination instance share stimulus
// and are checked every cycle against a transaction-level model of the load sequence.
module tb_sequenciador_carga;

  logic        clock;
  logic        reset_n;
  logic        iniciar;
  logic        entrada_valida;
  logic [15:0] entrada;

  logic        pronta6, oc6, pn6, pronta3, oc3, pn3;
  logic [2:0]  op6, op3;
  logic [15:0] a6, b6, c6, d6, e6, f6, soma6;
  logic [15:0] a3, b3, c3, d3, e3, f3, soma3;

  sequenciador_carga #(.N_DESTINOS(6)) u_dut6 (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar),
    .entrada_valida(entrada_valida), .entrada(entrada),
    .entrada_pronta(pronta6), .op(op6),
    .a(a6), .b(b6), .c(c6), .d(d6), .e(e6), .f(f6),
    .ocupado(oc6), .pronto(pn6), .soma(soma6)
  );

  sequenciador_carga #(.N_DESTINOS(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar),
    .entrada_valida(entrada_valida), .entrada(entrada),
    .entrada_pronta(pronta3), .op(op3),
    .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3),
    .ocupado(oc3), .pronto(pn3), .soma(soma3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: per instance, run phase (0 idle, 1 loading, 2 done), words taken so far, stored words, sum.
  int          m_fase [2];
  int          m_idx  [2];
  logic [15:0] m_dest [2][6];
  logic [15:0] m_soma [2];

  function automatic int n_of(input int k);
    return (k == 0) ? 6 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fase[k] = 0;
      m_idx[k]  = 0;
      m_soma[k] = 16'h0;
      for (int j = 0; j < 6; j++) m_dest[k][j] = 16'h0;
    end
  endtask

  task automatic model_update();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      case (m_fase[k])
        0: if (iniciar) begin
          m_fase[k] = 1;
          m_idx[k]  = 0;
          m_soma[k] = 16'h0;
        end
        1: if (entrada_valida) begin
          m_dest[k][m_idx[k]] = entrada;
          m_soma[k] = m_soma[k] + entrada;
          if (m_idx[k] == n_of(k) - 1) m_fase[k] = 2;
          else m_idx[k] = m_idx[k] + 1;
        end
        default: m_fase[k] = 0;
      endcase
    end
  endtask

  task automatic check_inst(input int k, input logic [2:0] o_op, input logic o_pr,
                            input logic o_oc, input logic o_pn, input logic [15:0] o_soma,
                            input logic [95:0] o_dest);
    string       p;
    logic [2:0]  exp_op;
    logic [15:0] exp_soma;
    p        = (k == 0) ? "n6" : "n3";
    exp_op   = (m_fase[k] == 1) ? 3'(m_idx[k]) : 3'b111;
`ifdef SEQUENCIADOR_CARGA_SOMA_EN
    exp_soma = m_soma[k];
`else
    exp_soma = 16'h0;
`endif
    check_eq({p, ".op"},      32'(o_op), 32'(exp_op));
    check_eq({p, ".pronta"},  32'(o_pr), 32'(m_fase[k] == 1));
    check_eq({p, ".ocupado"}, 32'(o_oc), 32'(m_fase[k] != 0));
    check_eq({p, ".pronto"},  32'(o_pn), 32'(m_fase[k] == 2));
    check_eq({p, ".soma"},    32'(o_soma), 32'(exp_soma));
    for (int j = 0; j < 6; j++)
      check_eq($sformatf("%s.dest%0d", p, j), 32'(o_dest[16*j +: 16]), 32'(m_dest[k][j]));
  endtask

  task automatic check_all();
    check_inst(0, op6, pronta6, oc6, pn6, soma6, {f6, e6, d6, c6, b6, a6});
    check_inst(1, op3, pronta3, oc3, pn3, soma3, {f3, e3, d3, c3, b3, a3});
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_all();
  endtask

  logic [15:0] words [6];

  // One run on the 6-destination instance; lat counts cycles from the iniciar cycle to pronto.
  task automatic run_seq(input int stall_at, input int stall_len, input int ign_at, output int lat);
    int  n, cyc, stalled;
    bit  seen, stall, xfer;
    n = 0; cyc = 0; stalled = 0; seen = 0;
    iniciar = 1'b1;
    entrada_valida = 1'b0;
    step();
    check_eq("start.op", 32'(op6), 32'd0);
    check_eq("start.soma", 32'(soma6), 32'd0);
    while (!seen && cyc < 40) begin
      stall = (n == stall_at) && (stalled < stall_len);
      if (stall) begin
        stalled++;
        check_eq("stall.op", 32'(op6), 32'd2);
      end
      iniciar        = (n == ign_at);
      entrada_valida = !stall && (n < 6);
      entrada        = words[(n < 6) ? n : 5];
      xfer           = entrada_valida && pronta6;
      step();
      cyc++;
      if (xfer) n++;
      if (pn6) seen = 1;
    end
    iniciar = 1'b0;
    entrada_valida = 1'b0;
    if (!seen) check_eq("run.timeout", 32'd0, 32'd1);
    lat = cyc + 1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] exp_s;
    reset_n = 1'b0;
    iniciar = 1'b0;
    entrada_valida = 1'b0;
    entrada = 16'h0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset_n = 1'b1;
    step();

    // Full run, no stalls
    for (int i = 0; i < 6; i++) words[i] = 16'(i + 1);
    run_seq(99, 0, 99, lat);
    check_eq("full.lat", 32'(lat), 32'd7);
    check_eq("full.a", 32'(a6), 32'h1);
    check_eq("full.f", 32'(f6), 32'h6);
`ifdef SEQUENCIADOR_CARGA_SOMA_EN
    exp_s = 16'h0015;
`else
    exp_s = 16'h0000;
`endif
    check_eq("full.soma", 32'(soma6), 32'(exp_s));

    // Stall of 3 cycles between words 2 and 3
    run_seq(2, 3, 99, lat);
    check_eq("stall.lat", 32'(lat), 32'd10);
    check_eq("stall.c", 32'(c6), 32'h3);
    check_eq("stall.d", 32'(d6), 32'h4);

    // Back-to-back run, iniciar the cycle after FIM
    run_seq(99, 0, 99, lat);
    check_eq("b2b.lat", 32'(lat), 32'd7);

    // iniciar during loading is ignored; 3-destination instance writes only a..c
    words = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'h0F0F};
    run_seq(99, 0, 1, lat);
    check_eq("ign.lat", 32'(lat), 32'd7);
    check_eq("ign.n3.c", 32'(c3), 32'hCCCC);
    check_eq("ign.n3.d", 32'(d3), 32'h0);
    check_eq("ign.n3.f", 32'(f3), 32'h0);
    check_eq("ign.n6.f", 32'(f6), 32'h0F0F);

    // Reset after two transfers
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    entrada_valida = 1'b1;
    entrada = 16'h1234;
    step();
    entrada = 16'h5678;
    step();
    entrada_valida = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("rst.op", 32'(op6), 32'h7);
    check_eq("rst.ocupado", 32'(oc6), 32'h0);
    check_eq("rst.a", 32'(a6), 32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) words[i] = 16'(16'h0100 + i);
    run_seq(99, 0, 99, lat);
    check_eq("rst.fresh.lat", 32'(lat), 32'd7);
    check_eq("rst.fresh.e", 32'(e6), 32'h0104);

    // Checksum wrap
    words = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_seq(99, 0, 99, lat);
`ifdef SEQUENCIADOR_CARGA_SOMA_EN
    exp_s = 16'h0001;
`else
    exp_s = 16'h0000;
`endif
    check_eq("wrap.soma6", 32'(soma6), 32'(exp_s));
    check_eq("wrap.soma3", 32'(soma3), 32'(exp_s));

    // Random traffic with occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      iniciar        = ($urandom_range(3) == 0);
      entrada_valida = ($urandom_range(2) != 0);
      entrada        = 16'($urandom);
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if ($urandom_range(63) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_carga.md
# sequenciador_carga

Sequencer that loads six 16-bit operand registers, one word at a time, from a single input bus. It sits in front of the multiplier datapath. It generates the 3-bit routing select used by the 1-to-6 distribution stage and owns registered copies of the six destinations, so downstream logic never sees a combinational hold loop. A valid/ready handshake paces the source, and a completion pulse tells the multiplier control that all operands are stable.

## Interface
- N_DESTINOS, 6, number of destinations loaded per run; legal range 1..6.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- iniciar  input  1  start request; sampled only in OCIOSO.
- entrada_valida  input  1  source has a word on `entrada`.
- entrada  input  16  data word.
- entrada_pronta  output  1  block accepts a word this cycle (ready).
- op  output  3  current destination index; 3'b111 when not loading.
- a, b, c, d, e, f  output  16 each  registered destinations 0..5.
- ocupado  output  1  high in CARREGA and FIM.
- pronto  output  1  one-cycle pulse when the last word is written.
- soma  output  16  running checksum; only meaningful with the macro enabled.

## Operation
- States: OCIOSO, CARREGA, FIM.
- OCIOSO:
  - op = 3'b111, entrada_pronta = 0.
  - On iniciar = 1: go to CARREGA, set op = 0, clear soma.
- CARREGA:
  - entrada_pronta = 1.
  - A transfer occurs when entrada_valida && entrada_pronta at the clock edge.
  - On a transfer, the destination selected by op (0→a … 5→f) takes `entrada`, and op increments.
  - If op == N_DESTINOS-1 at the transfer, go to FIM instead of incrementing.
  - Cycles without entrada_valida are stalls: nothing changes.
- FIM:
  - Lasts exactly one cycle; pronto = 1, op = 3'b111, entrada_pronta = 0.
  - Then returns to OCIOSO.
- Destinations hold their values between runs. Only a transfer or reset changes them. Destinations with index ≥ N_DESTINOS are never written.
- iniciar is ignored in CARREGA and FIM. A new run may start the cycle after FIM.
- op is never 3'b110 and never 3'b111 during CARREGA.
- Reset (reset_n = 0) at any time, including mid-run:
  - State returns to OCIOSO.
  - a..f = 0, op = 3'b111, soma = 0.
  - entrada_pronta, ocupado and pronto = 0.
  - Partially loaded data is discarded.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- iniciar high at edge k → ocupado and entrada_pronta high after edge k.
- Transfer at edge t → destination register updated after edge t; op advanced after edge t.
- Minimum run, with entrada_valida held high: N_DESTINOS transfer cycles plus 1 FIM cycle.
- pronto rises after the edge of the last transfer and falls after the next edge.
- When pronto is high, all loaded destinations already hold their final values.

## Configuration
- Macro: SEQUENCIADOR_CARGA_SOMA_EN.
- Defined:
  - soma clears when a run starts.
  - On every transfer, soma <= soma + entrada, modulo 2^16 (carry discarded).
  - soma is valid while pronto is high and holds its value until the next run or reset.
- Undefined: soma is tied to 16'h0000 and no adder is synthesized.

## Test plan
- Full run, no stalls:
  - Stimulus: reset, iniciar pulse, entrada_valida held high, words 16'h0001..16'h0006.
  - Required: op steps 0..5; a..f = 1..6; pronto is a single pulse 7 cycles after iniciar is sampled; soma = 16'h0015 (macro on).
- Stalls:
  - Stimulus: same run with entrada_valida low for 3 cycles between words 2 and 3.
  - Required: op holds at 2 during the stall; final a..f unchanged from the full-run result; pronto is 3 cycles later.
- Ignored start and partial width:
  - Stimulus: iniciar asserted during CARREGA, with N_DESTINOS = 3.
  - Required: iniciar has no effect; only a, b, c are written; d, e, f keep their prior values.
- Reset mid-run:
  - Stimulus: reset_n low after 2 transfers.
  - Required: a..f = 0, op = 3'b111, ocupado = 0, no pronto pulse.
  - Then: a fresh run completes normally.
- Checksum wrap:
  - Stimulus: words 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000.
  - Required: soma = 16'h0001 with the macro on; soma = 0 with it off.
- Back-to-back runs:
  - Stimulus: iniciar the cycle after FIM.
  - Required: second run starts immediately; op restarts at 0; soma is recleared.
